// File: rtl/cache_control.sv
// Control FSM for the 2-way, 8-set, 16-byte-line write-back cache.
// Sequences hits, write-back and line fill, and keeps saturating hit/miss counters.
module cache_control #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 mem_read,
   input  logic                 mem_write,
   output logic                 mem_resp,
   output logic                 pmem_read,
   output logic                 pmem_write,
   input  logic                 pmem_resp,
   input  logic                 ishit_w1,
   input  logic                 ishit_w2,
   input  logic                 isdirty_w1,
   input  logic                 isdirty_w2,
   input  logic                 lru_out,
   output logic                 load_dirty_w1,
   output logic                 load_valid_w1,
   output logic                 load_tag_w1,
   output logic                 load_datastore_w1,
   output logic                 load_dirty_w2,
   output logic                 load_valid_w2,
   output logic                 load_tag_w2,
   output logic                 load_datastore_w2,
   output logic                 load_lru,
   output logic                 datastore_in_mux_sel,
   output logic [1:0]           pmem_address_mux_sel,
   output logic [CNT_WIDTH-1:0] hit_count,
   output logic [CNT_WIDTH-1:0] miss_count
);

   // state     | meaning
   // IDLE      | lookup; read hits and LRU-way write hits complete here
   // WRITE_HIT | second cycle of a write hit to the non-LRU way
   // WRITEBACK | victim line written to pmem
   // ALLOCATE  | line read from pmem into victim way
   typedef enum logic [1:0] {IDLE, WRITE_HIT, WRITEBACK, ALLOCATE} state_t;

   state_t state, state_next;
   logic   miss_pending;
   logic   req, hit, hit_way, victim_dirty;
   logic   count_hit, count_miss;
   logic   load_way, ld_dirty, ld_valid, ld_tag, ld_data;

   assign req          = mem_read | mem_write;
   assign hit          = ishit_w1 | ishit_w2;
   assign hit_way      = ~ishit_w1;
   assign victim_dirty = lru_out ? isdirty_w2 : isdirty_w1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next           = state;
      mem_resp             = 1'b0;
      pmem_read            = 1'b0;
      pmem_write           = 1'b0;
      load_lru             = 1'b0;
      datastore_in_mux_sel = 1'b0;
      pmem_address_mux_sel = 2'b10;
      load_way             = 1'b0;
      ld_dirty             = 1'b0;
      ld_valid             = 1'b0;
      ld_tag               = 1'b0;
      ld_data              = 1'b0;
      count_hit            = 1'b0;
      count_miss           = 1'b0;
      case (state)
         IDLE: begin
            if (req && hit) begin
               count_hit = ~miss_pending;
               if (mem_write) begin
                  if (hit_way == lru_out) begin
                     datastore_in_mux_sel = 1'b1;
                     load_way             = hit_way;
                     ld_data              = 1'b1;
                     ld_dirty             = 1'b1;
                     load_lru             = 1'b1;
                     mem_resp             = 1'b1;
                  end else begin
                     // flip LRU first so the datapath way mux points at the hit way
                     load_lru   = 1'b1;
                     state_next = WRITE_HIT;
                  end
               end else begin
                  mem_resp = 1'b1;
                  load_lru = (hit_way == lru_out);
               end
            end else if (req) begin
               count_miss = 1'b1;
               state_next = victim_dirty ? WRITEBACK : ALLOCATE;
            end
         end
         WRITE_HIT: begin
            datastore_in_mux_sel = 1'b1;
            load_way             = lru_out;
            ld_data              = 1'b1;
            ld_dirty             = 1'b1;
            load_lru             = 1'b1;
            mem_resp             = 1'b1;
            state_next           = IDLE;
         end
         WRITEBACK: begin
            pmem_write           = 1'b1;
            pmem_address_mux_sel = {1'b0, lru_out};
            if (pmem_resp) state_next = ALLOCATE;
         end
         ALLOCATE: begin
            pmem_read = 1'b1;
            load_way  = lru_out;
            if (pmem_resp) begin
               ld_data    = 1'b1;
               ld_tag     = 1'b1;
               ld_valid   = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign load_dirty_w1     = ld_dirty & ~load_way;
   assign load_valid_w1     = ld_valid & ~load_way;
   assign load_tag_w1       = ld_tag   & ~load_way;
   assign load_datastore_w1 = ld_data  & ~load_way;
   assign load_dirty_w2     = ld_dirty &  load_way;
   assign load_valid_w2     = ld_valid &  load_way;
   assign load_tag_w2       = ld_tag   &  load_way;
   assign load_datastore_w2 = ld_data  &  load_way;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         miss_pending <= 1'b0;
         hit_count    <= '0;
         miss_count   <= '0;
      end else begin
         if (count_miss)    miss_pending <= 1'b1;
         else if (mem_resp) miss_pending <= 1'b0;
         if (count_hit && hit_count != '1)   hit_count  <= hit_count + 1'b1;
         if (count_miss && miss_count != '1) miss_count <= miss_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_cache_control.sv
// Directed self-checking bench for cache_control; a second 4-bit-counter
// instance shares the stimulus to exercise counter saturation.
module tb_cache_control;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic mem_read = 0, mem_write = 0, pmem_resp = 0;
   logic ishit_w1 = 0, ishit_w2 = 0, isdirty_w1 = 0, isdirty_w2 = 0, lru_out = 0;
   logic mem_resp, pmem_read, pmem_write;
   logic load_dirty_w1, load_valid_w1, load_tag_w1, load_datastore_w1;
   logic load_dirty_w2, load_valid_w2, load_tag_w2, load_datastore_w2;
   logic load_lru, datastore_in_mux_sel;
   logic [1:0] pmem_address_mux_sel;
   logic [15:0] hit_count, miss_count;
   logic s_mem_resp, s_pmem_read, s_pmem_write;
   logic s_ld1, s_lv1, s_lt1, s_lds1, s_ld2, s_lv2, s_lt2, s_lds2, s_lru, s_mux;
   logic [1:0] s_addr;
   logic [3:0] s_hit_count, s_miss_count;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   cache_control dut (
      .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
      .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_resp(pmem_resp), .ishit_w1(ishit_w1), .ishit_w2(ishit_w2),
      .isdirty_w1(isdirty_w1), .isdirty_w2(isdirty_w2), .lru_out(lru_out),
      .load_dirty_w1(load_dirty_w1), .load_valid_w1(load_valid_w1),
      .load_tag_w1(load_tag_w1), .load_datastore_w1(load_datastore_w1),
      .load_dirty_w2(load_dirty_w2), .load_valid_w2(load_valid_w2),
      .load_tag_w2(load_tag_w2), .load_datastore_w2(load_datastore_w2),
      .load_lru(load_lru), .datastore_in_mux_sel(datastore_in_mux_sel),
      .pmem_address_mux_sel(pmem_address_mux_sel),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   cache_control #(.CNT_WIDTH(4)) dut_sat (
      .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
      .mem_resp(s_mem_resp), .pmem_read(s_pmem_read), .pmem_write(s_pmem_write),
      .pmem_resp(pmem_resp), .ishit_w1(ishit_w1), .ishit_w2(ishit_w2),
      .isdirty_w1(isdirty_w1), .isdirty_w2(isdirty_w2), .lru_out(lru_out),
      .load_dirty_w1(s_ld1), .load_valid_w1(s_lv1),
      .load_tag_w1(s_lt1), .load_datastore_w1(s_lds1),
      .load_dirty_w2(s_ld2), .load_valid_w2(s_lv2),
      .load_tag_w2(s_lt2), .load_datastore_w2(s_lds2),
      .load_lru(s_lru), .datastore_in_mux_sel(s_mux),
      .pmem_address_mux_sel(s_addr),
      .hit_count(s_hit_count), .miss_count(s_miss_count)
   );

   // inputs change on the falling edge; outputs are sampled 1 ns later
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      mem_read = 0; mem_write = 0; pmem_resp = 0;
      ishit_w1 = 0; ishit_w2 = 0; isdirty_w1 = 0; isdirty_w2 = 0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clear_inputs();
      step();
      checks++;
      if ({mem_resp, pmem_read, pmem_write, load_lru, datastore_in_mux_sel} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl got %b want 00000",
                  {mem_resp, pmem_read, pmem_write, load_lru, datastore_in_mux_sel});
      end
      checks++;
      if (pmem_address_mux_sel !== 2'b10) begin
         errors++; $display("FAIL reset_addr got %b want 10", pmem_address_mux_sel);
      end
      checks++;
      if (hit_count !== 16'd0 || miss_count !== 16'd0) begin
         errors++; $display("FAIL reset_counts got %0d/%0d want 0/0", hit_count, miss_count);
      end
      reset = 1'b0;
      step();
   endtask

   task automatic test_read_hit();
      lru_out = 0; mem_read = 1; ishit_w1 = 1; #1;
      checks++;
      if (mem_resp !== 1'b1 || load_lru !== 1'b1) begin
         errors++; $display("FAIL rd_hit_w1 resp/lru got %b%b want 11", mem_resp, load_lru);
      end
      step(); clear_inputs(); #1;
      checks++;
      if (hit_count !== 16'd1) begin
         errors++; $display("FAIL rd_hit_w1_count got %0d want 1", hit_count);
      end
      mem_read = 1; ishit_w2 = 1; #1;
      checks++;
      if (mem_resp !== 1'b1 || load_lru !== 1'b0) begin
         errors++; $display("FAIL rd_hit_w2 resp/lru got %b%b want 10", mem_resp, load_lru);
      end
      step(); clear_inputs(); #1;
      checks++;
      if (hit_count !== 16'd2) begin
         errors++; $display("FAIL rd_hit_w2_count got %0d want 2", hit_count);
      end
   endtask

   task automatic test_write_hit();
      lru_out = 0; mem_write = 1; ishit_w2 = 1; #1;
      checks++;
      if (load_lru !== 1'b1 || mem_resp !== 1'b0 || load_datastore_w2 !== 1'b0) begin
         errors++;
         $display("FAIL wr_hit_c0 lru/resp/ds got %b%b%b want 100",
                  load_lru, mem_resp, load_datastore_w2);
      end
      step();
      lru_out = 1; #1;
      checks++;
      if ({load_datastore_w2, load_dirty_w2, load_lru, mem_resp, datastore_in_mux_sel} !== 5'b11111
          || load_datastore_w1 !== 1'b0) begin
         errors++;
         $display("FAIL wr_hit_c1 got %b ds1=%b want 11111 ds1=0",
                  {load_datastore_w2, load_dirty_w2, load_lru, mem_resp, datastore_in_mux_sel},
                  load_datastore_w1);
      end
      step(); clear_inputs(); lru_out = 0; #1;
      checks++;
      if (mem_resp !== 1'b0 || hit_count !== 16'd3) begin
         errors++; $display("FAIL wr_hit_done resp/count got %b/%0d want 0/3", mem_resp, hit_count);
      end
      // hit on the LRU way completes in one cycle
      mem_write = 1; ishit_w1 = 1; #1;
      checks++;
      if ({load_datastore_w1, load_dirty_w1, load_lru, mem_resp, datastore_in_mux_sel} !== 5'b11111) begin
         errors++;
         $display("FAIL wr_hit_lru got %b want 11111",
                  {load_datastore_w1, load_dirty_w1, load_lru, mem_resp, datastore_in_mux_sel});
      end
      step(); clear_inputs(); #1;
   endtask

   task automatic test_clean_miss();
      lru_out = 1; isdirty_w2 = 0; isdirty_w1 = 1; mem_read = 1; #1;
      checks++;
      if (mem_resp !== 1'b0 || pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
         errors++; $display("FAIL cmiss_idle got %b%b%b want 000", mem_resp, pmem_read, pmem_write);
      end
      for (int i = 0; i < 5; i++) begin
         step();
         if (i == 4) pmem_resp = 1;
         #1;
         checks++;
         if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address_mux_sel !== 2'b10) begin
            errors++;
            $display("FAIL cmiss_fill%0d rd/wr/addr got %b%b%b want 1010",
                     i, pmem_read, pmem_write, pmem_address_mux_sel);
         end
         checks++;
         if ({load_tag_w2, load_valid_w2, load_datastore_w2} !== ((i == 4) ? 3'b111 : 3'b000)
             || {load_tag_w1, load_valid_w1, load_datastore_w1} !== 3'b000) begin
            errors++;
            $display("FAIL cmiss_load%0d w2=%b w1=%b", i,
                     {load_tag_w2, load_valid_w2, load_datastore_w2},
                     {load_tag_w1, load_valid_w1, load_datastore_w1});
         end
      end
      step();
      pmem_resp = 0; ishit_w2 = 1; #1;
      checks++;
      if (mem_resp !== 1'b1 || pmem_read !== 1'b0) begin
         errors++; $display("FAIL cmiss_relookup resp/rd got %b%b want 10", mem_resp, pmem_read);
      end
      step(); clear_inputs(); #1;
      checks++;
      if (miss_count !== 16'd1 || hit_count !== 16'd4) begin
         errors++; $display("FAIL cmiss_counts got %0d/%0d want miss 1 hit 4", miss_count, hit_count);
      end
   endtask

   task automatic test_dirty_miss();
      lru_out = 0; isdirty_w1 = 1; mem_write = 1; #1;
      for (int i = 0; i < 3; i++) begin
         step();
         if (i == 2) pmem_resp = 1;
         #1;
         checks++;
         if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address_mux_sel !== 2'b00) begin
            errors++;
            $display("FAIL dmiss_wb%0d wr/rd/addr got %b%b%b want 1000",
                     i, pmem_write, pmem_read, pmem_address_mux_sel);
         end
      end
      step();
      pmem_resp = 0; #1;
      checks++;
      if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address_mux_sel !== 2'b10
          || load_datastore_w1 !== 1'b0) begin
         errors++;
         $display("FAIL dmiss_alloc0 rd/wr/addr/ds1 got %b%b%b%b want 10100",
                  pmem_read, pmem_write, pmem_address_mux_sel, load_datastore_w1);
      end
      step();
      pmem_resp = 1; #1;
      checks++;
      if ({load_datastore_w1, load_tag_w1, load_valid_w1} !== 3'b111 || load_datastore_w2 !== 1'b0) begin
         errors++;
         $display("FAIL dmiss_fill w1=%b ds2=%b want 111 0",
                  {load_datastore_w1, load_tag_w1, load_valid_w1}, load_datastore_w2);
      end
      step();
      pmem_resp = 0; isdirty_w1 = 0; ishit_w1 = 1; #1;
      checks++;
      if (mem_resp !== 1'b1 || load_datastore_w1 !== 1'b1 || load_dirty_w1 !== 1'b1) begin
         errors++;
         $display("FAIL dmiss_relookup resp/ds1/dirty1 got %b%b%b want 111",
                  mem_resp, load_datastore_w1, load_dirty_w1);
      end
      step(); clear_inputs();
      pmem_resp = 1; #1;
      step();
      pmem_resp = 0; #1;
      checks++;
      if (miss_count !== 16'd2 || hit_count !== 16'd4 || pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
         errors++;
         $display("FAIL dmiss_after miss/hit/rd/wr got %0d/%0d/%b%b want 2/4/00",
                  miss_count, hit_count, pmem_read, pmem_write);
      end
   endtask

   task automatic test_reset_mid_allocate();
      lru_out = 1; mem_read = 1; #1;
      step();
      checks++;
      if (pmem_read !== 1'b1) begin
         errors++; $display("FAIL rst_alloc_pre pmem_read got %b want 1", pmem_read);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || hit_count !== 16'd0 || miss_count !== 16'd0) begin
         errors++;
         $display("FAIL rst_alloc rd/wr/hit/miss got %b%b/%0d/%0d want 00/0/0",
                  pmem_read, pmem_write, hit_count, miss_count);
      end
      clear_inputs();
      step();
      reset = 1'b0;
      step();
      checks++;
      if (pmem_read !== 1'b0 || pmem_address_mux_sel !== 2'b10) begin
         errors++; $display("FAIL rst_alloc_idle rd/addr got %b%b want 010", pmem_read, pmem_address_mux_sel);
      end
   endtask

   task automatic test_saturation();
      lru_out = 0; mem_read = 1; ishit_w1 = 1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (i == 14) begin
            checks++;
            if (s_hit_count !== 4'd15) begin
               errors++; $display("FAIL sat_at15 got %0d want 15", s_hit_count);
            end
         end
      end
      clear_inputs(); #1;
      checks++;
      if (s_hit_count !== 4'd15 || hit_count !== 16'd20) begin
         errors++; $display("FAIL sat_hold got %0d/%0d want 15/20", s_hit_count, hit_count);
      end
   endtask

   initial begin
      test_reset();
      test_read_hit();
      test_write_hit();
      test_clean_miss();
      test_dirty_miss();
      test_reset_mid_allocate();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1);
   end

endmodule
